// File: rtl/spi_byte_shifter_pkg.sv
// Shared types and defaults for the SPI byte shifter.
// State encoding and default word width.
package spi_byte_shifter_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_byte_shifter_clk_edge_det.sv
// Synchronous edge detector for a divided clock carried as data.
// rise/fall are single-cycle and combinational from the history bit.
module clk_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= sig_in;
  end

  assign rise = sig_in & ~prev_q;
  assign fall = ~sig_in & prev_q;

endmodule

// File: rtl/spi_byte_shifter.sv
// Mode-0 serial byte shifter strobed by edges of a divided clock.
// Full duplex: mosi out on falls, miso sampled on rises.
module spi_byte_shifter
  import spi_byte_shifter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_5m,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  input  logic              miso
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              rdy_q, rdy_d;

  logic              rise, fall;
  logic [DATA_W-1:0] tx_nxt, rx_nxt;
  logic              tx_first, tx_next_bit;

  clk_edge_det u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(clk_5m),
    .rise  (rise),
    .fall  (fall)
  );

  // Bit order applies symmetrically to tx and rx
  assign tx_nxt = MSB_FIRST ? {tx_sh_q[DATA_W-2:0], 1'b0}
                            : {1'b0, tx_sh_q[DATA_W-1:1]};
  assign rx_nxt = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], miso}
                            : {miso, rx_sh_q[DATA_W-1:1]};
  assign tx_first    = MSB_FIRST ? tx_sh_q[DATA_W-1] : tx_sh_q[0];
  assign tx_next_bit = MSB_FIRST ? tx_nxt[DATA_W-1] : tx_nxt[0];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    sclk_d    = 1'b0;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    rdy_d     = rdy_q;
    unique case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        if (tx_valid && rdy_q) begin
          tx_sh_d = tx_data;
          rdy_d   = 1'b0;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (fall) begin
          cs_n_d    = 1'b0;
          mosi_d    = tx_first;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sclk_d = clk_5m;
        if (rise) rx_sh_d = rx_nxt;
        if (fall) begin
          if (bit_cnt_q != LAST) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            tx_sh_d   = tx_nxt;
            mosi_d    = tx_next_bit;
          end else begin
            cs_n_d    = 1'b1;
            sclk_d    = 1'b0;
            mosi_d    = 1'b0;
            rx_data_d = rx_sh_q;
            done_d    = 1'b1;
            rdy_d     = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      rdy_q     <= rdy_d;
    end
  end

  assign tx_ready = rdy_q;
  assign rx_data  = rx_data_q;
  assign done     = done_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule
